gcd_stream: RTL

- Parametrised successor to the team's 8-bit subtract/swap GCD unit.
- Computes gcd(a,b) of unsigned WIDTH-bit operands using the binary (Stein) algorithm: shifts and subtracts only, no divider.
- Uses a valid/ready handshake on input and output instead of start/ready.
- Handles zero operands and reports the iteration count for performance checks.
- Sits between an operand source and a result consumer on the datapath.

---
 rtl/gcd_stream.sv | 114 +++++++++++
 1 files changed

// File: rtl/gcd_stream.sv
// Streaming binary (Stein) GCD with valid/ready on both sides and a saturating
// iteration counter; one operand pair in flight, result held until consumed.
module gcd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CNT_W-1:0] out_cycles
);

  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, STRIP, REDUCE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d, cnt_inc;

  // Saturate rather than wrap so long runs still read as "at least max".
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          k_d   = '0;
          cnt_d = '0;
          if (in_a == '0 || in_b == '0) begin
            res_d   = in_a | in_b;
            cyc_d   = '0;
            state_d = DONE;
          end else begin
            state_d = STRIP;
          end
        end
      end
      STRIP: begin
        cnt_d = cnt_inc;
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        cnt_d = cnt_inc;
        if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q == b_q) begin
          // k only counts factors of two common to both operands, so no overflow.
          res_d   = a_q << k_q;
          cyc_d   = cnt_inc;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_gcd    = res_q;
  assign out_cycles = cyc_q;

endmodule
